keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 165 ++++++++++++++++
 tb/tb_keypad_encoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Keypad encoder: debounced key capture to a binary code with loadn strobe.
// Ports: clk, rst, enablen, keypad[NUM_KEYS] in; D, loadn, pgt_1hz, invalid_key out.
module keypad_encoder #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enablen,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic [CODE_W-1:0]   D,
  output logic                loadn,
  output logic                pgt_1hz,
  output logic                invalid_key
);

  localparam int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] cap_q, cap_d;
  logic [CODE_W-1:0]   d_q, d_d;
  logic                loadn_q, loadn_d;
  logic                inv_q, inv_d;
  logic [NUM_KEYS-1:0] sync1_q, ks;
  logic [TICK_W-1:0]   tick_q;
  logic                pgt_q;
  logic                ks_any;
  logic                ks_onehot;

  function automatic logic [CODE_W-1:0] enc(
    input logic [NUM_KEYS-1:0] v
  );
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (v[i]) r = CODE_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      ks      <= '0;
    end else begin
      sync1_q <= keypad;
      ks      <= sync1_q;
    end
  end

  assign ks_any = |ks;
  // Clearing the lowest set bit leaves zero only for a single key.
  assign ks_onehot =
    ks_any && ((ks & (ks - NUM_KEYS'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      d_q     <= '0;
      loadn_q <= 1'b1;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      d_q     <= d_d;
      loadn_q <= loadn_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    d_d     = d_q;
    loadn_d = 1'b1;
    inv_d   = 1'b0;
    if (!enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ks_onehot) begin
            cap_d   = ks;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else if (ks_any) begin
            inv_d   = 1'b1;
            state_d = HELD;
          end
        end
        DEBOUNCE: begin
          if (ks != cap_q) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            d_d     = enc(cap_q);
            loadn_d = 1'b0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!ks_any) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (ks_any) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The tick register fires on the edge the counter wraps, so the
  // first pulse follows the TICK_DIV-th edge sampled in timing mode.
  always_ff @(posedge clk) begin
    if (rst || enablen) begin
      tick_q <= '0;
      pgt_q  <= 1'b0;
    end else begin
      if (tick_q == TICK_LAST)
        tick_q <= '0;
      else
        tick_q <= tick_q + TICK_W'(1);
      pgt_q <= (tick_q == TICK_LAST);
    end
  end

  assign D           = d_q;
  assign loadn       = loadn_q;
  assign invalid_key = inv_q;
  assign pgt_1hz     = pgt_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with default parameters.
// Checks reset, debounce latency, glitch, multi-key, tick and reset abort.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enablen;
  logic [9:0] keypad;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1hz;
  logic       invalid_key;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int inv_cnt = 0;
  int pgt_cnt = 0;

  keypad_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .enablen     (enablen),
    .keypad      (keypad),
    .D           (D),
    .loadn       (loadn),
    .pgt_1hz     (pgt_1hz),
    .invalid_key (invalid_key)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!loadn) load_cnt++;
    if (invalid_key) inv_cnt++;
    if (pgt_1hz) pgt_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    enablen = 1'b1;
    keypad = '0;
    step(3);
    rst = 1'b0;
    chk("rst_D", int'(D), 0);
    chk("rst_loadn", int'(loadn), 1);
    chk("rst_pgt", int'(pgt_1hz), 0);
    chk("rst_inv", int'(invalid_key), 0);
    step(2);
    chk("idle_loadn", int'(loadn), 1);

    // key 9: loadn low exactly after edge k+6
    keypad = 10'b1000000000;
    step(1);
    step(5);
    chk("k9_early", int'(loadn), 1);
    step(1);
    chk("k9_loadn", int'(loadn), 0);
    chk("k9_D", int'(D), 9);
    step(1);
    chk("k9_one_wide", int'(loadn), 1);
    step(13);
    chk("k9_no_repeat", load_cnt, 1);
    keypad = '0;
    step(10);
    keypad = 10'b0000000001;
    step(10);
    chk("k0_count", load_cnt, 2);
    chk("k0_D", int'(D), 0);
    keypad = '0;
    step(10);

    // glitch on key 3, then a clean hold
    keypad = 10'b0000001000;
    step(2);
    keypad = '0;
    step(2);
    step(6);
    chk("glitch_no_load", load_cnt, 2);
    chk("glitch_D", int'(D), 0);
    keypad = 10'b0000001000;
    step(12);
    chk("k3_count", load_cnt, 3);
    chk("k3_D", int'(D), 3);
    keypad = '0;
    step(10);

    // two keys at once
    keypad = 10'b1000010000;
    step(10);
    chk("multi_inv", inv_cnt, 1);
    chk("multi_no_load", load_cnt, 3);
    chk("multi_D", int'(D), 3);
    keypad = '0;
    step(10);
    keypad = 10'b0000100000;
    step(10);
    chk("k5_count", load_cnt, 4);
    chk("k5_D", int'(D), 5);
    chk("k5_inv", inv_cnt, 1);
    keypad = '0;
    step(10);

    // timing mode: n counts edges sampling enablen low
    enablen = 1'b0;
    for (int n = 1; n <= 350; n++) begin
      if (n < 340)
        keypad = n[0] ? 10'b0000000100
                      : 10'b0010100000;
      else
        keypad = '0;
      step(1);
      chk($sformatf("pgt_%0d", n), int'(pgt_1hz),
          (n % 100 == 0) ? 1 : 0);
    end
    chk("tick_pulses", pgt_cnt, 3);
    chk("tick_no_load", load_cnt, 4);
    chk("tick_no_inv", inv_cnt, 1);
    chk("tick_D", int'(D), 5);
    enablen = 1'b1;
    step(150);
    chk("tick_stopped", pgt_cnt, 3);
    chk("entry_pgt", int'(pgt_1hz), 0);

    // reset aborts a key in debounce
    keypad = 10'b0010000000;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_loadn", int'(loadn), 1);
    chk("abort_D", int'(D), 0);
    step(3);
    chk("abort_no_load", load_cnt, 4);
    step(12);
    chk("k7_count", load_cnt, 5);
    chk("k7_D", int'(D), 7);
    keypad = '0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
